// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared types and constants for the M-extension issue controller.
// Sequencer states plus the funct3/funct7 encodings of the RISC-V M extension.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Bus between the issue controller (master) and the multi-cycle mul/div unit (slave).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            unit_start;
  logic            unit_kill;
  logic [2:0]      unit_op;
  logic [XLEN-1:0] unit_in1;
  logic [XLEN-1:0] unit_in2;
  logic            unit_done;
  logic [XLEN-1:0] unit_result;

  modport master (
    output unit_start, unit_kill, unit_op, unit_in1, unit_in2,
    input  unit_done, unit_result
  );

  modport slave (
    input  unit_start, unit_kill, unit_op, unit_in1, unit_in2,
    output unit_done, unit_result
  );
endinterface

// File: rtl/muldiv_issue_ctrl_fastpath.sv
// Combinational shortcut for divide corner cases (divide by zero, signed overflow).
// Only instantiated when MULDIV_DIVZERO_FAST_EN is defined.
module muldiv_fastpath
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic sgn_ovf;

  assign div_zero = (rs2_val_i == '0);
  assign sgn_ovf  = (rs1_val_i == MIN_NEG) && (rs2_val_i == '1);

  // Decide whether the architectural result is known without the unit, and what it is
  always_comb begin
    hit_o    = 1'b0;
    result_o = '0;
    case (funct3_i)
      F3_DIV: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = '1;
        end else if (sgn_ovf) begin
          hit_o    = 1'b1;
          result_o = MIN_NEG;
        end
      end
      F3_DIVU: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = '1;
        end
      end
      F3_REM: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = rs1_val_i;
        end else if (sgn_ovf) begin
          hit_o    = 1'b1;
          result_o = '0;
        end
      end
      F3_REMU: begin
        if (div_zero) begin
          hit_o    = 1'b1;
          result_o = rs1_val_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue sequencer between EX and the multi-cycle mul/div unit.
// Latches the op, pulses start, stalls the front end until the unit answers
// (or the watchdog fires), then returns one result-valid pulse.
// Optional feature: define MULDIV_DIVZERO_FAST_EN to resolve divide-by-zero and
// signed-overflow divides in the issue cycle without involving the unit.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  input  logic               is_muldiv_i,
  input  logic [2:0]         funct3_i,
  input  logic [XLEN-1:0]    rs1_val_i,
  input  logic [XLEN-1:0]    rs2_val_i,
  input  logic               flush_i,
  muldiv_unit_if.master      unit,
  output logic               stall_o,
  output logic               result_valid_o,
  output logic [XLEN-1:0]    result_o,
  output logic               timeout_o
);

  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] in1_q;
  logic [XLEN-1:0] in2_q;
  logic [XLEN-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic            start_q;

  logic            accept;
  logic            in_flight;
  logic            cnt_last;
  logic            wd_hit;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

`ifdef MULDIV_DIVZERO_FAST_EN
  muldiv_fastpath #(
    .XLEN(XLEN)
  ) u_fastpath (
    .funct3_i (funct3_i),
    .rs1_val_i(rs1_val_i),
    .rs2_val_i(rs2_val_i),
    .hit_o    (fast_hit),
    .result_o (fast_res)
  );
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // No new issue is taken while DONE: EX still holds the retiring instruction then.
  assign accept    = (state_q == IDLE) && issue_valid_i && is_muldiv_i && !flush_i;
  assign in_flight = (state_q == START) || (state_q == WAIT);
  assign cnt_last  = (cnt_q == CNT_W'(TIMEOUT - 1));
  // Done and flush both take priority over the watchdog in its last cycle.
  assign wd_hit    = (state_q == WAIT) && cnt_last && !unit.unit_done && !flush_i;

  assign stall_o        = accept || in_flight;
  assign result_valid_o = (state_q == DONE) && !flush_i;
  assign result_o       = result_q;
  assign timeout_o      = wd_hit;

  assign unit.unit_start = start_q;
  assign unit.unit_kill  = (in_flight && flush_i) || wd_hit;
  assign unit.unit_op    = op_q;
  assign unit.unit_in1   = in1_q;
  assign unit.unit_in2   = in2_q;

  // Sequencer: issue, wait for the unit (bounded by the watchdog), retire one result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3_i;
            in1_q <= rs1_val_i;
            in2_q <= rs2_val_i;
            if (fast_hit) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end else begin
              start_q <= 1'b1;
              state_q <= START;
            end
          end
        end
        START: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (unit.unit_done) begin
            result_q <= unit.unit_result;
            state_q  <= DONE;
          end else if (cnt_last) begin
            result_q <= '1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Scoreboard bench for muldiv_issue_ctrl: the driver pushes expected results,
// a negedge monitor pops and compares on every result_valid pulse.
module tb_muldiv_issue_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REM  = 3'd6;
  localparam logic [2:0] OP_REMU = 3'd7;

  typedef struct {
    logic [31:0] res;
    logic        to;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        is_muldiv;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic        timeout;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [31:0] model_res = '0;
  bit          to_seen = 0;

  muldiv_unit_if #(.XLEN(32)) uif ();

  muldiv_issue_ctrl #(
    .XLEN   (32),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .issue_valid_i (issue_valid),
    .is_muldiv_i   (is_muldiv),
    .funct3_i      (funct3),
    .rs1_val_i     (rs1),
    .rs2_val_i     (rs2),
    .flush_i       (flush),
    .unit          (uif),
    .stall_o       (stall),
    .result_valid_o(result_valid),
    .result_o      (result),
    .timeout_o     (timeout)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension result, straight from the ISA definition.
  function automatic logic [31:0] mext(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, su;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] a32, b32;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    su  = {32'b0, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    a32 = a;
    b32 = b;
    r   = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * su; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = a32 / b32;
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = a32 % b32;
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction through the controller. dly: WAIT cycle in which the unit
  // reports done (<1 or >TIMEOUT = never). flush_w: WAIT cycle carrying flush (-1 none).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int dly, input int flush_w, input bit flush_done);
    logic [31:0] u_res, exp_r;
    bit fast, done_now, fl_now, to_exp;
    fast = 0;
`ifdef MULDIV_DIVZERO_FAST_EN
    fast = (b == 0 && (op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU)) ||
           ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`endif
    step();
    issue_valid = 1; is_muldiv = 1; funct3 = op; rs1 = a; rs2 = b; flush = 0;
    uif.unit_done = 0;
    @(negedge clk);
    chk("issue stall", {31'b0, stall}, 1);
    chk("issue no start", {31'b0, uif.unit_start}, 0);
    chk("result hold", result, model_res);
    if (fast) begin
      exp_r = mext(op, a, b);
      model_res = exp_r;
      if (!flush_done) exp_q.push_back('{res: exp_r, to: 1'b0});
      step();
      issue_valid = 0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; flush = flush_done;
      @(negedge clk);
      chk("fast no start", {31'b0, uif.unit_start}, 0);
      chk("fast stall", {31'b0, stall}, 0);
      chk("fast valid", {31'b0, result_valid}, {31'b0, !flush_done});
      return;
    end
    step();
    issue_valid = 1'($urandom); is_muldiv = 1'($urandom);
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    uif.unit_done = 1'($urandom); uif.unit_result = $urandom;
    @(negedge clk);
    chk("start pulse", {31'b0, uif.unit_start}, 1);
    chk("start stall", {31'b0, stall}, 1);
    chk("start kill", {31'b0, uif.unit_kill}, 0);
    chk("unit op", {29'b0, uif.unit_op}, {29'b0, op});
    chk("unit in1", uif.unit_in1, a);
    chk("unit in2", uif.unit_in2, b);
    u_res = mext(uif.unit_op, uif.unit_in1, uif.unit_in2);
    done_now = 0; fl_now = 0; to_exp = 0;
    for (int w = 1; w <= TIMEOUT; w++) begin
      step();
      done_now = (w == dly);
      fl_now   = (w == flush_w);
      uif.unit_done   = done_now;
      uif.unit_result = done_now ? u_res : $urandom;
      flush           = fl_now;
      to_exp = (w == TIMEOUT) && !done_now && !fl_now;
      @(negedge clk);
      chk("wait stall", {31'b0, stall}, 1);
      chk("wait no start", {31'b0, uif.unit_start}, 0);
      chk("wait kill", {31'b0, uif.unit_kill}, {31'b0, fl_now || to_exp});
      chk("wait timeout", {31'b0, timeout}, {31'b0, to_exp});
      chk("op hold", {29'b0, uif.unit_op}, {29'b0, op});
      chk("in1 hold", uif.unit_in1, a);
      if (done_now || fl_now || w == TIMEOUT) break;
    end
    if (!fl_now) begin
      exp_r = to_exp ? 32'hFFFF_FFFF : mext(op, a, b);
      model_res = exp_r;
      if (!flush_done) exp_q.push_back('{res: exp_r, to: to_exp});
    end
    step();
    uif.unit_done = 0; uif.unit_result = $urandom;
    flush = !fl_now && flush_done;
    issue_valid = !fl_now && 1'($urandom); is_muldiv = 1;
    @(negedge clk);
    chk("retire stall", {31'b0, stall}, 0);
    chk("retire valid", {31'b0, result_valid}, {31'b0, !fl_now && !flush_done});
  endtask

  task automatic idle_checks();
    step();
    issue_valid = 1; is_muldiv = 0; flush = 0; uif.unit_done = 0;
    @(negedge clk);
    chk("non-muldiv stall", {31'b0, stall}, 0);
    step();
    issue_valid = 1; is_muldiv = 1; flush = 1;
    @(negedge clk);
    chk("flush idle stall", {31'b0, stall}, 0);
    step();
    issue_valid = 0; flush = 0; uif.unit_done = 1; uif.unit_result = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("idle no start", {31'b0, uif.unit_start}, 0);
    chk("idle done valid", {31'b0, result_valid}, 0);
    step();
    uif.unit_done = 0;
    @(negedge clk);
    chk("idle done ignored valid", {31'b0, result_valid}, 0);
    chk("idle done ignored result", result, model_res);
  endtask

  task automatic reset_mid_op();
    step();
    issue_valid = 1; is_muldiv = 1; funct3 = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    flush = 0; uif.unit_done = 0;
    @(negedge clk);
    chk("rst op stall", {31'b0, stall}, 1);
    step();
    issue_valid = 0;
    repeat (3) step();
    rst_n = 0;
    #1;
    chk("rst stall", {31'b0, stall}, 0);
    chk("rst valid", {31'b0, result_valid}, 0);
    chk("rst result", result, 0);
    chk("rst timeout", {31'b0, timeout}, 0);
    chk("rst start", {31'b0, uif.unit_start}, 0);
    chk("rst kill", {31'b0, uif.unit_kill}, 0);
    chk("rst op", {29'b0, uif.unit_op}, 0);
    chk("rst in1", uif.unit_in1, 0);
    chk("rst in2", uif.unit_in2, 0);
    model_res = '0;
    step();
    step();
    rst_n = 1;
    step();
    uif.unit_done = 1; uif.unit_result = 32'h1234_5678;
    @(negedge clk);
    chk("late done valid", {31'b0, result_valid}, 0);
    chk("late done stall", {31'b0, stall}, 0);
    step();
    uif.unit_done = 0;
    @(negedge clk);
    chk("late done valid2", {31'b0, result_valid}, 0);
    chk("late done result", result, 0);
  endtask

  // Monitor: every result_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      to_seen = 0;
    end else begin
      if (timeout) to_seen = 1;
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected result_valid: result %h with nothing pending", result);
        end else begin
          e = exp_q.pop_front();
          chk("result value", result, e.res);
          chk("timeout before result", {31'b0, to_seen}, {31'b0, e.to});
          to_seen = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clk = 0; rst_n = 0;
    issue_valid = 0; is_muldiv = 0; funct3 = 0; rs1 = 0; rs2 = 0; flush = 0;
    uif.unit_done = 0; uif.unit_result = 0;
    #2;
    chk("reset stall", {31'b0, stall}, 0);
    chk("reset valid", {31'b0, result_valid}, 0);
    chk("reset result", result, 0);
    chk("reset start", {31'b0, uif.unit_start}, 0);
    chk("reset kill", {31'b0, uif.unit_kill}, 0);
    chk("reset timeout", {31'b0, timeout}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_op(OP_MUL, 32'd3, 32'd5, 2, -1, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 10, -1, 0);
    run_op(OP_MUL, 32'd9, 32'd9, 3, 3, 0);
    run_op(OP_DIV, 32'd50, 32'd5, -1, -1, 0);
    run_op(OP_DIV, 32'd7, 32'd0, 2, -1, 0);
    run_op(OP_REMU, 32'd7, 32'd0, 1, -1, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3, -1, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2, -1, 0);
    run_op(OP_REM, 32'd100, 32'd7, 1, -1, 1);
    run_op(OP_MUL, 32'd11, 32'd13, TIMEOUT, -1, 0);
    idle_checks();

    for (int i = 0; i < 40; i++) begin
      int d, f;
      d = $urandom_range(1, 6);
      f = ($urandom_range(0, 5) == 0) ? $urandom_range(1, d) : -1;
      run_op(3'($urandom_range(0, 7)), pick(), pick(), d, f, $urandom_range(0, 7) == 0);
    end

    reset_mid_op();
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, -1, 0);

    step();
    issue_valid = 0; flush = 0;
    repeat (3) step();
    chk("pending results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
